mem_word_sequencer: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_word_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mem_word_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU-side memory sequencer: FSM state
// encoding and the default bus geometry.
package mem_bus_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 16;

  // Page (address[15:8]) that the downstream Memory block accepts writes for.
  localparam logic [7:0]  WRITE_PAGE_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_word_sequencer.sv
// mem_word_sequencer: turns byte / 16-bit word requests from the CPU
// datapath into byte cycles on the 8-bit Memory bus. Words are big-endian:
// high byte at A, low byte at A+1 (wrapping at the top of the address space).
// One request outstanding at a time; completion is a one-cycle resp_valid.
//
// Optional build macro MEM_WRITE_FAULT_EN adds a write_fault output that
// pulses with resp_valid when any byte of a write fell outside WRITE_PAGE.
module mem_word_sequencer
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT
`ifdef MEM_WRITE_FAULT_EN
  ,
  parameter logic [7:0]  WRITE_PAGE = WRITE_PAGE_DEFAULT
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_word,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [15:0]           req_wdata,
  output logic                  resp_valid,
  output logic [15:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_en,
  output logic [7:0]            mem_wdata,
`ifdef MEM_WRITE_FAULT_EN
  output logic                  write_fault,
`endif
  input  logic [7:0]            mem_rdata
);

  state_e                r_state;
  state_e                w_next_state;

  // Captured request
  logic                  r_write;
  logic                  r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_wdata;
  logic [7:0]            r_rdata_hi;

  // Memory-bus and response registers
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic                  r_mem_write_en;
  logic [7:0]            r_mem_wdata;
  logic [15:0]           r_resp_rdata;

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_addr_plus1;

  // Reset masks the handshake and bus strobes combinationally so that a reset
  // arriving mid-operation stops writes and completions in that same cycle.
  assign req_ready    = (r_state == IDLE) && !reset;
  assign w_accept     = req_ready && req_valid;
  assign resp_valid   = (r_state == RESP) && !reset;
  assign mem_write_en = r_mem_write_en && !reset;
  assign mem_address  = r_mem_address;
  assign mem_wdata    = r_mem_wdata;
  assign resp_rdata   = r_resp_rdata;

  // Low-byte address; natural truncation gives the 0xFFFF -> 0x0000 wrap.
  assign w_addr_plus1 = r_addr + ADDR_WIDTH'(1);

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: the default assignment first guarantees no path leaves
  // w_next_state unassigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_next_state = FIRST;
      FIRST:   w_next_state = r_word ? SECOND : RESP;
      SECOND:  w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Request capture on acceptance.
  // NOTE: these are data-path holding registers, only read after being loaded
  // by an accepted request, so they carry no reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_write <= req_write;
      r_word  <= req_word;
      r_addr  <= req_address;
      r_wdata <= req_wdata;
    end
  end

  // Memory bus drive: address/data are loaded one edge ahead of the byte
  // cycle that uses them and hold their value in IDLE and RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_address  <= '0;
      r_mem_write_en <= 1'b0;
      r_mem_wdata    <= 8'h00;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_mem_address  <= req_address;
            r_mem_write_en <= req_write;
            if (req_write) r_mem_wdata <= req_word ? req_wdata[15:8] : req_wdata[7:0];
          end
        end
        FIRST: begin
          if (r_word) begin
            r_mem_address <= w_addr_plus1;
            if (r_write) r_mem_wdata <= r_wdata[7:0];
          end else begin
            r_mem_write_en <= 1'b0;
          end
        end
        SECOND:  r_mem_write_en <= 1'b0;
        default: ;
      endcase
    end
  end

  // Read-data assembly: high byte parked in FIRST of a word, result
  // published on entry to RESP and held until the next completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_resp_rdata <= 16'h0000;
    end else begin
      unique case (r_state)
        FIRST: begin
          if (r_word) r_rdata_hi   <= mem_rdata;
          else        r_resp_rdata <= r_write ? 16'h0000 : {8'h00, mem_rdata};
        end
        SECOND:  r_resp_rdata <= r_write ? 16'h0000 : {r_rdata_hi, mem_rdata};
        default: ;
      endcase
    end
  end

`ifdef MEM_WRITE_FAULT_EN
  logic r_fault;

  assign write_fault = resp_valid && r_fault;

  // Off-page tracking: flag set if any byte cycle of a write leaves WRITE_PAGE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_fault <= req_write && (req_address[ADDR_WIDTH-1 -: 8] != WRITE_PAGE);
    end else if (r_state == FIRST && r_word && r_write &&
                 (w_addr_plus1[ADDR_WIDTH-1 -: 8] != WRITE_PAGE)) begin
      r_fault <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_word_sequencer.sv
// Testbench for mem_word_sequencer: behavioural byte memory, request-level
// reference model, response and write scoreboards, directed and random traffic.
module tb_mem_word_sequencer;
  import mem_bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_word;
  logic [15:0] req_address, req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] mem_address;
  logic        mem_write_en;
  logic [7:0]  mem_wdata, mem_rdata;
`ifdef MEM_WRITE_FAULT_EN
  logic        write_fault;
`endif

  mem_word_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_word(req_word), .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
`ifdef MEM_WRITE_FAULT_EN
    .write_fault(write_fault),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Environment memory (combinational read, write on posedge) and model image
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign mem_rdata = mem[mem_address];
  always @(posedge clock) if (mem_write_en) mem[mem_address] <= mem_wdata;

  typedef struct { logic [15:0] rdata; logic fault; int unsigned acc; int unsigned lat; } resp_t;
  typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request-level model: what a request must do to memory and return.
  task automatic model(input bit wr, input bit wd, input logic [15:0] a,
                       input logic [15:0] wdat, input int unsigned acc);
    resp_t       e;
    logic [15:0] a1;
    a1      = a + 16'd1;
    e.acc   = acc;
    e.lat   = wd ? 3 : 2;
    e.fault = 1'b0;
    e.rdata = 16'h0000;
    if (wr) begin
      if (wd) begin
        wr_q.push_back('{addr: a,  data: wdat[15:8]});
        wr_q.push_back('{addr: a1, data: wdat[7:0]});
        ref_mem[a]  = wdat[15:8];
        ref_mem[a1] = wdat[7:0];
        e.fault = (a[15:8] != 8'hFF) || (a1[15:8] != 8'hFF);
      end else begin
        wr_q.push_back('{addr: a, data: wdat[7:0]});
        ref_mem[a] = wdat[7:0];
        e.fault = (a[15:8] != 8'hFF);
      end
    end else begin
      e.rdata = wd ? {ref_mem[a], ref_mem[a1]} : {8'h00, ref_mem[a]};
    end
    resp_q.push_back(e);
  endtask

  // Response monitor
  always @(negedge clock) begin
    if (resp_valid) begin
      check("resp_expected", resp_q.size() != 0, 1);
      if (resp_q.size() != 0) begin
        resp_t e;
        e = resp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_latency", cyc - e.acc, e.lat);
`ifdef MEM_WRITE_FAULT_EN
        check("write_fault", write_fault, e.fault);
`endif
      end
    end
  end

  // Memory write monitor
  always @(negedge clock) begin
    if (mem_write_en) begin
      check("write_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        wr_t w;
        w = wr_q.pop_front();
        check("write_addr", mem_address, w.addr);
        check("write_data", mem_wdata, w.data);
      end
    end
  end

  // Driver: called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit wr, input bit wd, input logic [15:0] a,
                       input logic [15:0] wdat, input bit use_model,
                       output int unsigned acc);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_word = wd;
    req_address = a; req_wdata = wdat;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    acc = cyc;
    if (!req_ready) begin
      check("ready_timeout", req_ready, 1);
    end else if (use_model) begin
      model(wr, wd, a, wdat, acc);
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("drain", resp_q.size() + wr_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned acc, prev_acc;
    bit          prev_word, have_prev;
    logic [7:0]  old_41;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[16'h0010] = 8'hAB; ref_mem[16'h0010] = 8'hAB;
    mem[16'h0011] = 8'hCD; ref_mem[16'h0011] = 8'hCD;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
    req_address = 16'h0000; req_wdata = 16'h0000;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 16'h0000);
    check("rst_mem_address", mem_address, 16'h0000);
    check("rst_mem_write_en", mem_write_en, 0);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", req_ready, 1);

    // Directed cases
    issue(0, 1, 16'h0010, 16'h0000, 1, acc);   // word read -> 0xABCD
    issue(0, 0, 16'h0011, 16'h0000, 1, acc);   // byte read -> 0x00CD
    issue(1, 1, 16'hFF20, 16'h1234, 1, acc);   // word write
    issue(0, 1, 16'hFF20, 16'h0000, 1, acc);   // read back 0x1234
    issue(0, 1, 16'hFFFF, 16'h0000, 1, acc);   // wrap to 0x0000
    issue(1, 0, 16'h0050, 16'h0077, 1, acc);   // off-page byte write
    issue(1, 0, 16'hFF50, 16'h0088, 1, acc);   // in-page byte write
    issue(1, 1, 16'hFFFF, 16'hA55A, 1, acc);   // word write wrapping off-page
    drain();

    // Reset while in SECOND of a word write to 0xFF40
    old_41 = ref_mem[16'hFF41];
    issue(1, 1, 16'hFF40, 16'hBEEF, 0, acc);
    wr_q.push_back('{addr: 16'hFF40, data: 8'hBE});
    ref_mem[16'hFF40] = 8'hBE;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("abort_write_en", mem_write_en, 0);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_ready_in_reset", req_ready, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_ready_after", req_ready, 1);
    check("abort_hi_written", mem[16'hFF40], 8'hBE);
    check("abort_lo_untouched", mem[16'hFF41], old_41);
    drain();

    // Randomized traffic with back-to-back throughput checks
    have_prev = 1'b0;
    prev_acc  = 0;
    prev_word = 1'b0;
    for (int k = 0; k < 300; k++) begin
      int unsigned gap, sel;
      bit          wr, wd;
      gap = $urandom_range(0, 2);
      sel = $urandom_range(0, 4);
      wr  = 1'($urandom);
      wd  = 1'($urandom);
      case (sel)
        0:       a = {8'hFF, 4'h0, 4'($urandom)};
        1:       a = {12'h000, 4'($urandom)};
        2:       a = 16'hFFFF;
        3:       a = 16'hFFFE;
        default: a = 16'($urandom);
      endcase
      repeat (gap) @(negedge clock);
      issue(wr, wd, a, 16'($urandom), 1, acc);
      if (have_prev && gap == 0) check("throughput", acc - prev_acc, prev_word ? 4 : 3);
      have_prev = 1'b1;
      prev_acc  = acc;
      prev_word = wd;
    end
    drain();

    // Memory image must agree with the model after all traffic
    for (int i = 0; i < 65536; i++) begin
      if (mem[i] !== ref_mem[i]) check("mem_image", {16'(i), 8'h00, mem[i]}, {16'(i), 8'h00, ref_mem[i]});
    end
    check("mem_image_ff40", mem[16'hFF40], ref_mem[16'hFF40]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
